// File: rtl/seg_pkg.sv
// seg_pkg: active-low segment patterns, digit indices and BCD FSM states for count_seg_display
package seg_pkg;
  localparam logic [6:0] SEG_0 = 7'h40, SEG_1 = 7'h79, SEG_2 = 7'h24, SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19, SEG_5 = 7'h12, SEG_6 = 7'h02, SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00, SEG_9 = 7'h10, SEG_A = 7'h08, SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46, SEG_D = 7'h21, SEG_E = 7'h06, SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] DIGIT_ONES = 2'd0, DIGIT_TENS = 2'd1, DIGIT_SPARE = 2'd2, DIGIT_OPT = 2'd3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, WIDTH shift cycles after start, then one DONE cycle
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);
  bcd_state_t state, state_nx;
  logic [2:0] cnt;
  logic [WIDTH-1:0] sh;
  logic [7:0] bcd, adj;
  logic last;
  assign last = cnt == 3'(WIDTH - 1);
  always_ff @(posedge fclk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (start ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_comb begin
    adj[7:4] = bcd[7:4] >= 4'd5 ? bcd[7:4] + 4'd3 : bcd[7:4];
    adj[3:0] = bcd[3:0] >= 4'd5 ? bcd[3:0] + 4'd3 : bcd[3:0];
  end
  always_ff @(posedge fclk or posedge reset)
    if (reset) begin
      cnt <= '0;
      sh  <= '0;
      bcd <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
      sh  <= bin;
      bcd <= '0;
    end else if (state == SHIFT) begin
      cnt <= cnt + 3'd1;
      sh  <= sh << 1;
      bcd <= {adj[6:0], sh[WIDTH-1]};
    end
  assign tens = bcd[7:4];
  assign ones = bcd[3:0];
endmodule

// File: rtl/count_seg_display.sv
// count_seg_display: scans count (decimal, digits 1:0) and opt (digit 3) onto a 4-digit active-low display.
// Define LZ_BLANK_EN to blank a leading-zero tens digit.
module count_seg_display
  import seg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int WIDTH      = 5
) (
  input  logic             fclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [1:0]       opt,
  output logic [6:0]       seg,
  output logic [3:0]       an,
  output logic             dp
);
  localparam int DIV = CLK_HZ / REFRESH_HZ - 1;
  localparam int DW = DIV > 0 ? $clog2(DIV + 1) : 1;
  logic [DW-1:0] div;
  logic [1:0] idx, opt_cap, opt_shown;
  logic [3:0] tens, ones, tens_shown, ones_shown;
  logic tick, start, busy, done;
  logic [6:0] seg_nx, tens_seg;
  assign tick = div == DW'(DIV);
  assign start = tick && idx == DIGIT_OPT && !busy;
  assign dp = 1'b1;
  bin2bcd_seq #(.WIDTH(WIDTH)) u_bcd (
    .fclk (fclk),
    .reset(reset),
    .start(start),
    .bin  (count),
    .busy (busy),
    .done (done),
    .tens (tens),
    .ones (ones)
  );
`ifdef LZ_BLANK_EN
  assign tens_seg = tens_shown == 4'd0 ? SEG_BLANK : seg_decode(tens_shown);
`else
  assign tens_seg = seg_decode(tens_shown);
`endif
  always_comb
    seg_nx = idx == DIGIT_ONES ? seg_decode(ones_shown) :
             idx == DIGIT_TENS ? tens_seg :
             idx == DIGIT_SPARE ? SEG_BLANK : seg_decode({2'b00, opt_shown});
  // Shown registers change only on done, so a scan never mixes old and new digits.
  always_ff @(posedge fclk or posedge reset)
    if (reset) begin
      div        <= '0;
      idx        <= DIGIT_ONES;
      an         <= 4'b1111;
      seg        <= SEG_BLANK;
      opt_cap    <= '0;
      opt_shown  <= '0;
      tens_shown <= '0;
      ones_shown <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
        an  <= ~(4'b0001 << idx);
        seg <= seg_nx;
      end
      if (start) opt_cap <= opt;
      if (done) begin
        tens_shown <= tens;
        ones_shown <= ones;
        opt_shown  <= opt_cap;
      end
    end
endmodule
